// File: rtl/alu_serial_unit.sv
// rtl/alu_serial_unit.sv - bit-serial handshaked ALU responder (add/sub/logic/slt/eq)
//
// Purpose: accepts one {A, B, Mode} request on a valid/ready channel, computes
// the result one bit per clock (LSB first) and returns Results plus
// Overflow/Carry/zero on a second valid/ready channel.
//
// Optional feature macro: ALU_LOGIC_BYPASS_EN
//   When defined, the bitwise modes (010..101) finish in a single BUSY cycle.
//   Arithmetic, slt and eq modes always take WIDTH BUSY cycles.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid, in_ready     request handshake
//   A, B, Mode             operands and operation code
//   out_valid, out_ready   result handshake
//   Results                WIDTH-bit result
//   Overflow, Carry, zero  result flags

module alu_serial_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       Mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Results,
    output logic             Overflow,
    output logic             Carry,
    output logic             zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] M_ADD = 3'b000;
    localparam logic [2:0] M_SUB = 3'b001;
    localparam logic [2:0] M_NOT = 3'b010;
    localparam logic [2:0] M_AND = 3'b011;
    localparam logic [2:0] M_OR  = 3'b100;
    localparam logic [2:0] M_XOR = 3'b101;
    localparam logic [2:0] M_SLT = 3'b110;
    localparam logic [2:0] M_EQ  = 3'b111;

    logic [1:0]       state;
    logic [CW-1:0]    count;
    // Operands shift right each BUSY cycle so bit 0 is always the current bit.
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [2:0]       mode_q;
    // Holds the WIDTH-1 result bits produced so far; the current bit is
    // prepended combinationally to form the full word on the last cycle.
    logic [WIDTH-2:0] res_sr;
    // Carry chain for add/sub/slt; doubles as the "all bits equal" accumulator for eq.
    logic             carry_q;

    logic             subtract;
    logic             a_bit;
    logic             b_bit;
    logic             sum_bit;
    logic             cout;
    logic             eq_acc;
    logic             r_bit;
    logic [WIDTH-1:0] res_cat;
    logic             add_ovf;
    logic             sub_ovf;
    logic [WIDTH-1:0] final_res;
    logic             final_ovf;
    logic             final_carry;
    logic             bypass_now;
`ifdef ALU_LOGIC_BYPASS_EN
    logic [WIDTH-1:0] logic_word;
`endif

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

    always_comb begin
        subtract = (mode_q == M_SUB) || (mode_q == M_SLT);
        a_bit    = a_sh[0];
        b_bit    = subtract ? ~b_sh[0] : b_sh[0];
        sum_bit  = a_bit ^ b_bit ^ carry_q;
        cout     = (a_bit & b_bit) | (carry_q & (a_bit ^ b_bit));
        eq_acc   = carry_q & ~(a_sh[0] ^ b_sh[0]);

        case (mode_q)
            M_NOT:   r_bit = ~a_sh[0];
            M_AND:   r_bit = a_sh[0] & b_sh[0];
            M_OR:    r_bit = a_sh[0] | b_sh[0];
            M_XOR:   r_bit = a_sh[0] ^ b_sh[0];
            M_EQ:    r_bit = 1'b0;
            default: r_bit = sum_bit;
        endcase
        res_cat = {r_bit, res_sr};

        // On the last cycle a_sh[0]/b_sh[0] are the operand MSBs and sum_bit is R[msb].
        add_ovf = (a_sh[0] == b_sh[0]) && (sum_bit != a_sh[0]);
        sub_ovf = (a_sh[0] != b_sh[0]) && (sum_bit != a_sh[0]);

        final_res   = res_cat;
        final_ovf   = 1'b0;
        final_carry = 1'b0;
        case (mode_q)
            M_ADD: begin
                final_ovf   = add_ovf;
                final_carry = cout;
            end
            M_SUB: begin
                final_ovf   = sub_ovf;
                final_carry = cout;
            end
            M_SLT:   final_res = WIDTH'(sum_bit ^ sub_ovf);
            M_EQ:    final_res = WIDTH'(eq_acc);
            default: final_res = res_cat;
        endcase

`ifdef ALU_LOGIC_BYPASS_EN
        case (mode_q)
            M_NOT:   logic_word = ~a_sh;
            M_AND:   logic_word = a_sh & b_sh;
            M_OR:    logic_word = a_sh | b_sh;
            default: logic_word = a_sh ^ b_sh;
        endcase
        bypass_now = (mode_q >= M_NOT) && (mode_q <= M_XOR);
`else
        bypass_now = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            count    <= '0;
            a_sh     <= '0;
            b_sh     <= '0;
            mode_q   <= '0;
            res_sr   <= '0;
            carry_q  <= 1'b0;
            Results  <= '0;
            Overflow <= 1'b0;
            Carry    <= 1'b0;
            zero     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_sh    <= A;
                        b_sh    <= B;
                        mode_q  <= Mode;
                        count   <= '0;
                        res_sr  <= '0;
                        carry_q <= (Mode == M_SUB) || (Mode == M_SLT) || (Mode == M_EQ);
                        state   <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (bypass_now) begin
`ifdef ALU_LOGIC_BYPASS_EN
                        Results  <= logic_word;
                        zero     <= (logic_word == '0);
`endif
                        Overflow <= 1'b0;
                        Carry    <= 1'b0;
                        state    <= S_DONE;
                    end else begin
                        a_sh    <= a_sh >> 1;
                        b_sh    <= b_sh >> 1;
                        res_sr  <= res_cat[WIDTH-1:1];
                        carry_q <= (mode_q == M_EQ) ? eq_acc : cout;
                        count   <= count + 1'b1;
                        if (count == LAST) begin
                            Results  <= final_res;
                            Overflow <= final_ovf;
                            Carry    <= final_carry;
                            zero     <= (final_res == '0);
                            state    <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_unit.sv
// tb/tb_alu_serial_unit.sv - table-driven self-checking bench for alu_serial_unit

module tb_alu_serial_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] A;
    logic [7:0] B;
    logic [2:0] Mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] Results;
    logic       Overflow;
    logic       Carry;
    logic       zero;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_serial_unit #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Mode      (Mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Results   (Results),
        .Overflow  (Overflow),
        .Carry     (Carry),
        .zero      (zero)
    );

    typedef struct {
        logic [2:0] mode;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       ovf;
        logic       cry;
        logic       zr;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int exp_latency(input logic [2:0] m);
`ifdef ALU_LOGIC_BYPASS_EN
        if (m >= 3'b010 && m <= 3'b101) return 1;
`endif
        return 8;
    endfunction

    // Issue one request and wait for out_valid; leaves the result pending (out_ready low).
    task automatic issue(input logic [2:0] m, input logic [7:0] a, input logic [7:0] b,
                         output int lat);
        @(negedge clk);
        chk("in_ready_before_accept", 32'(in_ready), 32'd1);
        A = a; B = b; Mode = m; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // Later input changes must not affect the latched operation.
        A = ~a; B = ~b; Mode = ~m;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic drain();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("in_ready_after_handshake", 32'(in_ready), 32'd1);
        chk("out_valid_after_handshake", 32'(out_valid), 32'd0);
    endtask

    initial begin
        int lat;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; Mode = '0;

        vecs[0]  = '{3'b000, 8'h7F, 8'h01, 8'h80, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{3'b000, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b1, 1'b1};
        vecs[2]  = '{3'b001, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{3'b001, 8'h05, 8'h05, 8'h00, 1'b0, 1'b1, 1'b1};
        vecs[4]  = '{3'b110, 8'hFF, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{3'b111, 8'h3C, 8'h3C, 8'h01, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{3'b111, 8'h3C, 8'h3D, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{3'b010, 8'h0F, 8'h00, 8'hF0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{3'b011, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{3'b100, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{3'b101, 8'hA5, 8'hFF, 8'h5A, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{3'b110, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{3'b001, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{3'b000, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1};
        vecs[14] = '{3'b110, 8'h80, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{3'b011, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_results", 32'(Results), 32'd0);
        chk("reset_flags", {29'd0, Overflow, Carry, zero}, 32'd0);

        for (int i = 0; i < 16; i++) begin
            issue(vecs[i].mode, vecs[i].a, vecs[i].b, lat);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(exp_latency(vecs[i].mode)));
            chk($sformatf("v%0d_results", i), 32'(Results), 32'(vecs[i].res));
            chk($sformatf("v%0d_overflow", i), 32'(Overflow), 32'(vecs[i].ovf));
            chk($sformatf("v%0d_carry", i), 32'(Carry), 32'(vecs[i].cry));
            chk($sformatf("v%0d_zero", i), 32'(zero), 32'(vecs[i].zr));
            drain();
        end

        // Backpressure: result held for 5 cycles with out_ready low.
        issue(3'b101, 8'hA5, 8'hFF, lat);
        chk("bp_latency", 32'(lat), 32'(exp_latency(3'b101)));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp_hold%0d_results", k), 32'(Results), 32'h5A);
            chk($sformatf("bp_hold%0d_out_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("bp_hold%0d_in_ready", k), 32'(in_ready), 32'd0);
        end
        drain();

        // in_ready must stay low while BUSY; a request presented then is ignored.
        @(negedge clk);
        A = 8'h10; B = 8'h20; Mode = 3'b000; in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("busy_in_ready", 32'(in_ready), 32'd0);
        A = 8'hFF; B = 8'hFF; Mode = 3'b010;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("busy_in_ready_later", 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("busy_ignore_results", 32'(Results), 32'h30);
        drain();

        // Reset on the 3rd BUSY cycle of an add discards the operation.
        @(negedge clk);
        A = 8'h7F; B = 8'h01; Mode = 3'b000; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_results", 32'(Results), 32'd0);
        chk("midrst_flags", {29'd0, Overflow, Carry, zero}, 32'd0);
        issue(3'b000, 8'h02, 8'h03, lat);
        chk("postrst_latency", 32'(lat), 32'd8);
        chk("postrst_results", 32'(Results), 32'h05);
        chk("postrst_flags", {29'd0, Overflow, Carry, zero}, 32'd0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
